io_write_arbiter: RTL

IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

---
 rtl/io_write_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/io_write_arbiter.sv
// Purpose: merges PORT_COUNT Octavo I/O write ports into one valid/ready stream via per-port holding slots and round-robin grant.
// Latency: 2 cycles minimum from io_wren to out_valid (slot load, then output register load); one word per cycle sustained.
// Backpressure: out_ready=0 freezes the output register; a full slot raises io_write_EF, and writes into a full, ungranted slot are dropped and flagged in overflow.
module io_write_arbiter #(
  parameter int WORD_WIDTH       = 36,
  parameter int PORT_COUNT       = 2,
  parameter int PORT_INDEX_WIDTH = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [PORT_COUNT-1:0]            io_wren,
  input  logic [PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
  output logic [PORT_COUNT-1:0]            io_write_EF,
  output logic                             out_valid,
  output logic [WORD_WIDTH-1:0]            out_data,
  output logic [PORT_INDEX_WIDTH-1:0]      out_port,
  input  logic                             out_ready,
  output logic [PORT_COUNT-1:0]            overflow
);

  // One holding slot per port.
  logic [WORD_WIDTH-1:0]       slot_data [PORT_COUNT];
  logic [PORT_COUNT-1:0]       slot_full;
  logic [PORT_INDEX_WIDTH-1:0] rr_ptr;

  // Arbitration results for the current cycle.
  logic                        out_free;
  logic                        grant_vld;
  logic [PORT_INDEX_WIDTH-1:0] grant_idx;
  logic [WORD_WIDTH-1:0]       grant_data;
  logic [PORT_COUNT-1:0]       grant_vec;
  int                          scan_dist;
  int                          best_dist;

  // The full flag comes straight from the slot register, so Octavo never sees a path from its own strobe.
  assign io_write_EF = slot_full;

  // Output register can take a new word when empty or when its current word is being consumed.
  assign out_free = !out_valid || out_ready;

  // Round-robin pick: the full slot at the smallest circular distance from rr_ptr wins.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    scan_dist  = 0;
    best_dist  = PORT_COUNT;
    for (int i = 0; i < PORT_COUNT; i++) begin
      scan_dist = i - int'(rr_ptr);
      if (scan_dist < 0) begin
        scan_dist = scan_dist + PORT_COUNT;
      end
      if (slot_full[i] && (scan_dist < best_dist)) begin
        best_dist  = scan_dist;
        grant_vld  = 1'b1;
        grant_idx  = PORT_INDEX_WIDTH'(i);
        grant_data = slot_data[i];
      end
    end
  end

  // Per-port grant strobe, only when the output register actually takes the word.
  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      grant_vec[i] = out_free && grant_vld && (grant_idx == PORT_INDEX_WIDTH'(i));
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
      rr_ptr    <= '0;
    end else if (out_free) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_port  <= grant_idx;
        if (int'(grant_idx) == PORT_COUNT - 1) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_idx + PORT_INDEX_WIDTH'(1);
        end
      end else begin
        // Nothing to send: drop valid but keep the last data/port visible.
        out_valid <= 1'b0;
      end
    end
  end

  // Slot load/drain and sticky overflow; a slot granted this cycle may be refilled at the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      slot_full <= '0;
      overflow  <= '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PORT_COUNT; i++) begin
        if (io_wren[i]) begin
          if (!slot_full[i] || grant_vec[i]) begin
            slot_data[i] <= io_write_data[i*WORD_WIDTH +: WORD_WIDTH];
            slot_full[i] <= 1'b1;
          end else begin
            overflow[i] <= 1'b1;
          end
        end else if (grant_vec[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

endmodule
